// File: rtl/axi_lite_i2c_cmd_bridge.sv
// AXI4-Lite slave that turns register writes/reads into an ordered command stream
// for an I2C master, with a first-word-fall-through command FIFO and a read reply timeout.
module axi_lite_i2c_cmd_bridge #(
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    FIFO_DEPTH     = 4,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = 32'h1233_0000,
  parameter int                    ADDR_SPAN_BITS = 16,
  parameter int                    TIMEOUT_CYCLES = 1024
) (
  input  logic                          ACLK,
  input  logic                          ARESET,
  input  logic                          AWVALID,
  output logic                          AWREADY,
  input  logic [ADDR_WIDTH-1:0]         AWADDR,
  input  logic                          WVALID,
  output logic                          WREADY,
  input  logic [DATA_WIDTH-1:0]         WDATA,
  input  logic [DATA_WIDTH/8-1:0]       WSTRB,
  output logic                          BVALID,
  input  logic                          BREADY,
  output logic [1:0]                    BRESP,
  input  logic                          ARVALID,
  output logic                          ARREADY,
  input  logic [ADDR_WIDTH-1:0]         ARADDR,
  output logic                          RVALID,
  input  logic                          RREADY,
  output logic [DATA_WIDTH-1:0]         RDATA,
  output logic [1:0]                    RRESP,
  output logic                          CMD_VALID,
  input  logic                          CMD_READY,
  output logic                          CMD_RD,
  output logic [ADDR_SPAN_BITS-1:0]     CMD_ADDR,
  output logic [DATA_WIDTH-1:0]         CMD_DATA,
  input  logic                          RD_RSP_VALID,
  input  logic [DATA_WIDTH-1:0]         RD_RSP_DATA,
  input  logic                          RD_RSP_ERR,
  output logic                          RD_ABORT,
  output logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL
);

  localparam int STRB_W  = DATA_WIDTH / 8;
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int LVL_W   = PTR_W + 1;
  localparam int ENTRY_W = 1 + ADDR_SPAN_BITS + DATA_WIDTH;
  localparam int TMR_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic       {W_IDLE, W_RESP} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_PUSH, R_WAIT, R_RESP} r_state_e;

  function automatic logic addr_hit(input logic [ADDR_WIDTH-1:0] a);
    return a[ADDR_WIDTH-1:ADDR_SPAN_BITS] == BASE_ADDR[ADDR_WIDTH-1:ADDR_SPAN_BITS];
  endfunction

  w_state_e                  w_state_q, w_state_d;
  logic                      aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [ADDR_WIDTH-1:0]     aw_addr_q, aw_addr_d;
  logic [DATA_WIDTH-1:0]     w_data_q, w_data_d;
  logic [STRB_W-1:0]         w_strb_q, w_strb_d;
  logic [1:0]                bresp_q, bresp_d;

  r_state_e                  r_state_q, r_state_d;
  logic [ADDR_SPAN_BITS-1:0] ar_off_q, ar_off_d;
  logic [DATA_WIDTH-1:0]     rdata_q, rdata_d;
  logic [1:0]                rresp_q, rresp_d;
  logic [TMR_W-1:0]          timer_q, timer_d;
  logic                      rd_abort_q, rd_abort_d;

  logic [ENTRY_W-1:0]        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]          count_q, count_d;
  logic                      full_q, full_d;

  logic                      both_held, wr_ok, wr_push, wr_commit, rd_push, push, pop, empty;
  logic [ENTRY_W-1:0]        push_entry, head;

  // Arbitration: a write commit always owns the single push port; a read waits a cycle.
  assign empty      = (count_q == '0);
  assign both_held  = aw_held_q && w_held_q && (w_state_q == W_IDLE);
  assign wr_ok      = addr_hit(aw_addr_q) && (&w_strb_q);
  assign wr_push    = both_held && wr_ok && !full_q;
  assign wr_commit  = both_held && (!wr_ok || !full_q);
  assign rd_push    = (r_state_q == R_PUSH) && !full_q && !wr_push;
  assign push       = wr_push || rd_push;
  assign pop        = !empty && CMD_READY;
  assign push_entry = wr_push ? {1'b0, aw_addr_q[ADDR_SPAN_BITS-1:0], w_data_q}
                              : {1'b1, ar_off_q, {DATA_WIDTH{1'b0}}};
  assign head       = empty ? '0 : mem[rd_ptr_q];

  assign AWREADY    = !aw_held_q && (w_state_q == W_IDLE);
  assign WREADY     = !w_held_q && (w_state_q == W_IDLE);
  assign BVALID     = (w_state_q == W_RESP);
  assign BRESP      = bresp_q;
  assign ARREADY    = (r_state_q == R_IDLE);
  assign RVALID     = (r_state_q == R_RESP);
  assign RDATA      = rdata_q;
  assign RRESP      = rresp_q;
  assign RD_ABORT   = rd_abort_q;
  assign CMD_VALID  = !empty;
  assign CMD_RD     = head[ENTRY_W-1];
  assign CMD_ADDR   = head[ENTRY_W-2 -: ADDR_SPAN_BITS];
  assign CMD_DATA   = head[DATA_WIDTH-1:0];
  assign FIFO_LEVEL = count_q;

  // NOTE: every variable gets its default before any branch, so no path leaves one unassigned (no latch).
  always_comb begin
    w_state_d = w_state_q;
    aw_held_d = aw_held_q;
    aw_addr_d = aw_addr_q;
    w_held_d  = w_held_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    bresp_d   = bresp_q;
    if (AWVALID && AWREADY) begin
      aw_held_d = 1'b1;
      aw_addr_d = AWADDR;
    end
    if (WVALID && WREADY) begin
      w_held_d = 1'b1;
      w_data_d = WDATA;
      w_strb_d = WSTRB;
    end
    unique case (w_state_q)
      W_IDLE: if (wr_commit) begin
        w_state_d = W_RESP;
        aw_held_d = 1'b0;
        w_held_d  = 1'b0;
        bresp_d   = wr_push ? RESP_OKAY : RESP_SLVERR;
      end
      W_RESP: if (BREADY) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_d  = r_state_q;
    ar_off_d   = ar_off_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    timer_d    = timer_q;
    rd_abort_d = 1'b0;
    unique case (r_state_q)
      R_IDLE: if (ARVALID) begin
        if (addr_hit(ARADDR)) begin
          ar_off_d  = ARADDR[ADDR_SPAN_BITS-1:0];
          r_state_d = R_PUSH;
        end else begin
          rdata_d   = '0;
          rresp_d   = RESP_SLVERR;
          r_state_d = R_RESP;
        end
      end
      R_PUSH: if (rd_push) begin
        timer_d   = '0;
        r_state_d = R_WAIT;
      end
      R_WAIT: begin
        if (RD_RSP_VALID) begin
          rdata_d   = RD_RSP_DATA;
          rresp_d   = RD_RSP_ERR ? RESP_SLVERR : RESP_OKAY;
          r_state_d = R_RESP;
        end else if (timer_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
          rd_abort_d = 1'b1;
          rdata_d    = '0;
          rresp_d    = RESP_SLVERR;
          r_state_d  = R_RESP;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      R_RESP: if (RREADY) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  // Full comes from the registered level, so a pop cannot free a slot for a push in the same cycle.
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + LVL_W'(1);
      2'b01:   count_d = count_q - LVL_W'(1);
      default: count_d = count_q;
    endcase
    full_d = (count_d == LVL_W'(FIFO_DEPTH));
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      w_state_q  <= W_IDLE;
      aw_held_q  <= 1'b0;
      aw_addr_q  <= '0;
      w_held_q   <= 1'b0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      bresp_q    <= RESP_OKAY;
      r_state_q  <= R_IDLE;
      ar_off_q   <= '0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
      timer_q    <= '0;
      rd_abort_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
    end else begin
      w_state_q  <= w_state_d;
      aw_held_q  <= aw_held_d;
      aw_addr_q  <= aw_addr_d;
      w_held_q   <= w_held_d;
      w_data_q   <= w_data_d;
      w_strb_q   <= w_strb_d;
      bresp_q    <= bresp_d;
      r_state_q  <= r_state_d;
      ar_off_q   <= ar_off_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      timer_q    <= timer_d;
      rd_abort_q <= rd_abort_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
    end
  end

  // NOTE: FIFO storage has no reset; entries are only visible once the level says they were written.
  always_ff @(posedge ACLK) begin
    if (push) mem[wr_ptr_q] <= push_entry;
  end

endmodule

// File: tb/tb_axi_lite_i2c_cmd_bridge.sv
// Directed self-checking bench for axi_lite_i2c_cmd_bridge (default parameters).
module tb_axi_lite_i2c_cmd_bridge;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic [31:0] AWADDR, WDATA;
  logic [3:0]  WSTRB;
  logic [1:0]  BRESP, RRESP;
  logic        ARVALID, ARREADY, RVALID, RREADY;
  logic [31:0] ARADDR, RDATA;
  logic        CMD_VALID, CMD_READY, CMD_RD;
  logic [15:0] CMD_ADDR;
  logic [31:0] CMD_DATA;
  logic        RD_RSP_VALID, RD_RSP_ERR, RD_ABORT;
  logic [31:0] RD_RSP_DATA;
  logic [2:0]  FIFO_LEVEL;

  int total = 0;
  int bad   = 0;
  int abort_cnt = 0;

  axi_lite_i2c_cmd_bridge dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR),
    .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR),
    .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_RD(CMD_RD),
    .CMD_ADDR(CMD_ADDR), .CMD_DATA(CMD_DATA),
    .RD_RSP_VALID(RD_RSP_VALID), .RD_RSP_DATA(RD_RSP_DATA), .RD_RSP_ERR(RD_RSP_ERR),
    .RD_ABORT(RD_ABORT), .FIFO_LEVEL(FIFO_LEVEL)
  );

  always #5 ACLK = ~ACLK;

  always @(negedge ACLK) if (RD_ABORT) abort_cnt++;

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // All tasks start and end just after a falling edge.
  task automatic wr_issue(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    bit aw_done = 0, w_done = 0, aw_hs, w_hs;
    AWADDR = addr; WDATA = data; WSTRB = strb;
    AWVALID = 1'b1; WVALID = 1'b1;
    for (int i = 0; i < 50 && !(aw_done && w_done); i++) begin
      aw_hs = AWVALID && AWREADY;
      w_hs  = WVALID && WREADY;
      @(negedge ACLK);
      if (aw_hs) begin AWVALID = 1'b0; aw_done = 1; end
      if (w_hs)  begin WVALID  = 1'b0; w_done  = 1; end
    end
    AWVALID = 1'b0; WVALID = 1'b0;
    check("wr_accept", {62'd0, aw_done, w_done}, 64'd3);
  endtask

  task automatic wait_b(input string tag, input logic [1:0] exp_resp);
    bit seen = 0;
    logic [1:0] resp = 2'bxx;
    BREADY = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (BVALID) begin
        seen = 1; resp = BRESP;
        @(negedge ACLK);
        break;
      end
      @(negedge ACLK);
    end
    BREADY = 1'b0;
    check({tag, "_bvalid"}, 64'(seen), 64'd1);
    check({tag, "_bresp"}, 64'(resp), 64'(exp_resp));
  endtask

  task automatic rd_issue(input logic [31:0] addr);
    bit done = 0, hs;
    ARADDR = addr; ARVALID = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      hs = ARREADY;
      @(negedge ACLK);
      if (hs) done = 1;
    end
    ARVALID = 1'b0;
    check("rd_accept", 64'(done), 64'd1);
  endtask

  task automatic poll_r(input string tag, input int budget, output int cycles);
    bit seen = 0;
    cycles = -1;
    for (int i = 0; i < budget; i++) begin
      if (RVALID) begin seen = 1; cycles = i; break; end
      @(negedge ACLK);
    end
    check({tag, "_rvalid"}, 64'(seen), 64'd1);
  endtask

  task automatic take_r(input string tag, input logic [31:0] exp_data, input logic [1:0] exp_resp);
    check({tag, "_rdata"}, 64'(RDATA), 64'(exp_data));
    check({tag, "_rresp"}, 64'(RRESP), 64'(exp_resp));
    RREADY = 1'b1;
    @(negedge ACLK);
    RREADY = 1'b0;
  endtask

  task automatic pop_one(input string tag, input logic rd, input logic [15:0] addr, input logic [31:0] data);
    check({tag, "_cmd_valid"}, 64'(CMD_VALID), 64'd1);
    check({tag, "_cmd"}, 64'({CMD_RD, CMD_ADDR, CMD_DATA}), 64'({rd, addr, data}));
    CMD_READY = 1'b1;
    @(negedge ACLK);
    CMD_READY = 1'b0;
  endtask

  initial begin
    int  cyc;
    int  a0;
    bit  saw;
    ARESET = 1'b1;
    AWVALID = 0; AWADDR = 0; WVALID = 0; WDATA = 0; WSTRB = 0; BREADY = 0;
    ARVALID = 0; ARADDR = 0; RREADY = 0; CMD_READY = 0;
    RD_RSP_VALID = 0; RD_RSP_DATA = 0; RD_RSP_ERR = 0;
    repeat (3) @(negedge ACLK);
    ARESET = 1'b0;

    // Reset state
    check("rst_bvalid", 64'(BVALID), 64'd0);
    check("rst_rvalid", 64'(RVALID), 64'd0);
    check("rst_cmd_valid", 64'(CMD_VALID), 64'd0);
    check("rst_level", 64'(FIFO_LEVEL), 64'd0);
    check("rst_abort", 64'(RD_ABORT), 64'd0);
    check("rst_resps", 64'({BRESP, RRESP}), 64'd0);
    check("rst_rdata", 64'(RDATA), 64'd0);

    // 1: AW first, W two cycles later
    AWADDR = 32'h1233_0002; AWVALID = 1'b1;
    @(negedge ACLK); AWVALID = 1'b0;
    @(negedge ACLK);
    @(negedge ACLK);
    WDATA = 32'h1; WSTRB = 4'hF; WVALID = 1'b1;
    @(negedge ACLK); WVALID = 1'b0;
    wait_b("t1", 2'b00);
    check("t1_level", 64'(FIFO_LEVEL), 64'd1);
    pop_one("t1_pop", 1'b0, 16'h0002, 32'h1);

    // 2: fill the FIFO, the fifth write stalls until one pop
    for (int i = 0; i < 4; i++) begin
      wr_issue(32'h1233_0000 + 32'(4 * i), 32'h100 + 32'(i), 4'hF);
      wait_b("t2_ok", 2'b00);
    end
    check("t2_level_full", 64'(FIFO_LEVEL), 64'd4);
    wr_issue(32'h1233_0010, 32'h104, 4'hF);
    saw = 0;
    for (int i = 0; i < 10; i++) begin
      if (BVALID) saw = 1;
      @(negedge ACLK);
    end
    check("t2_stall_no_b", 64'(saw), 64'd0);
    check("t2_stall_level", 64'(FIFO_LEVEL), 64'd4);
    pop_one("t2_pop0", 1'b0, 16'h0000, 32'h100);
    wait_b("t2_fifth", 2'b00);
    check("t2_level_after", 64'(FIFO_LEVEL), 64'd4);
    for (int i = 1; i < 5; i++)
      pop_one("t2_order", 1'b0, 16'(4 * i), 32'h100 + 32'(i));
    check("t2_level_empty", 64'(FIFO_LEVEL), 64'd0);

    // 3: address miss, partial strobe, read miss
    wr_issue(32'h1234_AA1D, 32'hDEAD, 4'hF);
    wait_b("t3_wmiss", 2'b10);
    wr_issue(32'h1233_0008, 32'hBEEF, 4'h3);
    wait_b("t3_wstrb", 2'b10);
    check("t3_no_push", 64'(FIFO_LEVEL), 64'd0);
    rd_issue(32'h0000_0DAD);
    check("t3_rvalid_next", 64'(RVALID), 64'd1);
    take_r("t3_rmiss", 32'h0, 2'b10);
    check("t3_rd_no_push", 64'(FIFO_LEVEL), 64'd0);

    // 4: read hit with reply after 5 cycles, then an error reply
    rd_issue(32'h1233_0004);
    repeat (5) @(negedge ACLK);
    RD_RSP_DATA = 32'h0A0A; RD_RSP_ERR = 1'b0; RD_RSP_VALID = 1'b1;
    @(negedge ACLK); RD_RSP_VALID = 1'b0;
    poll_r("t4_ok", 5, cyc);
    check("t4_latency", 64'(cyc), 64'd0);
    take_r("t4_ok", 32'h0A0A, 2'b00);
    pop_one("t4_cmd", 1'b1, 16'h0004, 32'h0);
    rd_issue(32'h1233_0004);
    repeat (3) @(negedge ACLK);
    RD_RSP_DATA = 32'h1; RD_RSP_ERR = 1'b1; RD_RSP_VALID = 1'b1;
    @(negedge ACLK); RD_RSP_VALID = 1'b0; RD_RSP_ERR = 1'b0;
    poll_r("t4_err", 5, cyc);
    take_r("t4_err", 32'h1, 2'b10);
    pop_one("t4_cmd_err", 1'b1, 16'h0004, 32'h0);

    // 5: timeout; AR accepted, pushed next edge, TIMEOUT_CYCLES of waiting
    a0 = abort_cnt;
    rd_issue(32'h1233_0040);
    poll_r("t5", 2000, cyc);
    check("t5_latency", 64'(cyc), 64'd1025);
    check("t5_abort_with_rvalid", 64'(RD_ABORT), 64'd1);
    RD_RSP_DATA = 32'h7777; RD_RSP_VALID = 1'b1;
    @(negedge ACLK); RD_RSP_VALID = 1'b0;
    take_r("t5_late_in_resp", 32'h0, 2'b10);
    RD_RSP_VALID = 1'b1;
    @(negedge ACLK); RD_RSP_VALID = 1'b0;
    saw = 0;
    for (int i = 0; i < 4; i++) begin
      if (RVALID) saw = 1;
      @(negedge ACLK);
    end
    check("t5_late_in_idle", 64'(saw), 64'd0);
    check("t5_one_abort", 64'(abort_cnt - a0), 64'd1);
    pop_one("t5_cmd", 1'b1, 16'h0040, 32'h0);

    // 6: write commit and read push collide; write goes first
    AWADDR = 32'h1233_0010; WDATA = 32'hBEEF; WSTRB = 4'hF;
    ARADDR = 32'h1233_0020;
    AWVALID = 1'b1; WVALID = 1'b1; ARVALID = 1'b1;
    @(negedge ACLK);
    AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
    wait_b("t6_w", 2'b00);
    check("t6_level", 64'(FIFO_LEVEL), 64'd2);
    pop_one("t6_first", 1'b0, 16'h0010, 32'hBEEF);
    pop_one("t6_second", 1'b1, 16'h0020, 32'h0);

    // 6b: reset while the read is waiting and a write is in flight
    wr_issue(32'h1233_0030, 32'h55, 4'hF);
    wait_b("t6_pre", 2'b00);
    wr_issue(32'h1233_0034, 32'h66, 4'hF);
    ARESET = 1'b1;
    repeat (2) @(negedge ACLK);
    ARESET = 1'b0;
    check("t6_rst_level", 64'(FIFO_LEVEL), 64'd0);
    check("t6_rst_cmd_valid", 64'(CMD_VALID), 64'd0);
    saw = 0;
    BREADY = 1'b1; RREADY = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (RVALID || BVALID || RD_ABORT) saw = 1;
      @(negedge ACLK);
    end
    BREADY = 1'b0; RREADY = 1'b0;
    check("t6_rst_no_resp", 64'(saw), 64'd0);
    check("t6_rst_idle", 64'({ARREADY, AWREADY, WREADY}), 64'd7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
